// File: rtl/ipg_tx_arb.sv
// ipg_tx_arb: round-robin IPG message arbiter and chunk serializer.
// In: clk, reset (async, active-low), req_valid/len/addr/payload, tx_budget.
// Out: req_ready, tx_data/tx_len/tx_valid, busy, grant_idx, msg_done, drop_cnt.
module ipg_tx_arb #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 16,
  parameter int ADR_WIDTH   = 40,
  parameter int MAX_PAYLOAD = 512,
  parameter int HDR_BITS    = HDR_WIDTH + ADR_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*HDR_WIDTH-1:0]   req_len,
  input  logic [NUM_REQ*ADR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*MAX_PAYLOAD-1:0] req_payload,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [5:0]                     tx_budget,
  output logic [DATA_WIDTH-1:0]          tx_data,
  output logic [5:0]                     tx_len,
  output logic                           tx_valid,
  output logic                           busy,
  output logic [2:0]                     grant_idx,
  output logic                           msg_done,
  output logic [7:0]                     drop_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;

  localparam logic [HDR_WIDTH-1:0] MAX_LEN =
    HDR_WIDTH'(MAX_PAYLOAD);
  localparam int PAD = DATA_WIDTH - HDR_BITS;

  logic [1:0]             state_q, state_d;
  logic [2:0]             rr_q, rr_d;
  logic [HDR_WIDTH-1:0]   len_q, len_d;
  logic [ADR_WIDTH-1:0]   addr_q, addr_d;
  logic [MAX_PAYLOAD-1:0] pay_q, pay_d;
  logic [HDR_WIDTH-1:0]   remain_q, remain_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [5:0]             tx_len_q, tx_len_d;
  logic                   msg_done_q, msg_done_d;
  logic [2:0]             grant_q, grant_d;
  logic [7:0]             drop_q, drop_d;

  logic                   found;
  logic [2:0]             pick;
  logic                   take;
  logic [HDR_WIDTH-1:0]   sel_len;
  logic [ADR_WIDTH-1:0]   sel_addr;
  logic [MAX_PAYLOAD-1:0] sel_pay;
  logic                   sel_legal;
  logic [5:0]             n;
  logic [DATA_WIDTH-1:0]  mask;

  // Two passes give the rotated priority: rr_q..top first,
  // then wrap to 0..rr_q-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && i >= int'(rr_q)) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && i < int'(rr_q)) begin
        found = 1'b1;
        pick  = 3'(i);
      end
    end
  end

  assign take = reset && (state_q == ST_IDLE) && found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = take && (pick == 3'(i));
    end
  end

  always_comb begin
    sel_len  = '0;
    sel_addr = '0;
    sel_pay  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == 3'(i)) begin
        sel_len  = req_len[i*HDR_WIDTH +: HDR_WIDTH];
        sel_addr = req_addr[i*ADR_WIDTH +: ADR_WIDTH];
        sel_pay  = req_payload[i*MAX_PAYLOAD +: MAX_PAYLOAD];
      end
    end
  end

  assign sel_legal = (sel_len != '0) && (sel_len <= MAX_LEN);

  // Chunk size is bounded by both the budget and what is left.
  always_comb begin
    n = (HDR_WIDTH'(tx_budget) < remain_q) ?
      tx_budget : remain_q[5:0];
    mask = ~({DATA_WIDTH{1'b1}} >> n);
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    len_d      = len_q;
    addr_d     = addr_q;
    pay_d      = pay_q;
    remain_d   = remain_q;
    grant_d    = grant_q;
    drop_d     = drop_q;
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
    tx_len_d   = '0;
    msg_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          grant_d = pick;
          rr_d = (pick == 3'(NUM_REQ-1)) ?
            3'd0 : pick + 3'd1;
          if (sel_legal) begin
            len_d    = sel_len;
            addr_d   = sel_addr;
            // MSB-align so bit len-1 leads the stream.
            pay_d    = sel_pay << (MAX_LEN - sel_len);
            remain_d = sel_len;
            state_d  = ST_HDR;
          end else if (drop_q != 8'hff) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      ST_HDR: begin
        // The header is never split across cycles.
        if (int'(tx_budget) >= HDR_BITS) begin
          tx_valid_d = 1'b1;
          tx_len_d   = 6'(HDR_BITS);
          tx_data_d  =
            DATA_WIDTH'({len_q, addr_q}) << PAD;
          state_d    = ST_PAY;
        end
      end
      ST_PAY: begin
        if (n != '0) begin
          tx_valid_d = 1'b1;
          tx_len_d   = n;
          tx_data_d  =
            pay_q[MAX_PAYLOAD-1 -: DATA_WIDTH] & mask;
          pay_d      = pay_q << n;
          remain_d   = remain_q - HDR_WIDTH'(n);
          if (remain_q == HDR_WIDTH'(n)) begin
            msg_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      pay_q      <= '0;
      remain_q   <= '0;
      grant_q    <= '0;
      drop_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_len_q   <= '0;
      msg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      pay_q      <= pay_d;
      remain_q   <= remain_d;
      grant_q    <= grant_d;
      drop_q     <= drop_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_len_q   <= tx_len_d;
      msg_done_q <= msg_done_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign tx_len    = tx_len_q;
  assign msg_done  = msg_done_q;
  assign grant_idx = grant_q;
  assign drop_cnt  = drop_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ipg_tx_arb.sv
// tb_ipg_tx_arb: directed and randomized checks of ipg_tx_arb.
// Reference model keeps each message as a queue of pending bits.
module tb_ipg_tx_arb;
  localparam int N  = 2;
  localparam int MP = 512;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*16-1:0] req_len;
  logic [N*40-1:0] req_addr;
  logic [N*MP-1:0] req_payload;
  logic [N-1:0]    req_ready;
  logic [5:0]      tx_budget;
  logic [63:0]     tx_data;
  logic [5:0]      tx_len;
  logic            tx_valid;
  logic            busy;
  logic [2:0]      grant_idx;
  logic            msg_done;
  logic [7:0]      drop_cnt;

  int vecs;
  int errs;

  always #5 clk = ~clk;

  ipg_tx_arb dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_len(req_len),
    .req_addr(req_addr), .req_payload(req_payload),
    .req_ready(req_ready), .tx_budget(tx_budget),
    .tx_data(tx_data), .tx_len(tx_len),
    .tx_valid(tx_valid), .busy(busy),
    .grant_idx(grant_idx), .msg_done(msg_done),
    .drop_cnt(drop_cnt)
  );

  // phase: 0 waiting for a grant, 1 header owed, 2 payload owed
  int          m_phase;
  bit          m_bits[$];
  logic [15:0] m_len;
  logic [39:0] m_addr;
  int          m_rr;
  int          m_gidx;
  int          m_drop;
  logic        e_valid;
  logic        e_done;
  logic [63:0] e_data;
  logic [5:0]  e_len;

  function automatic void model_reset();
    m_phase = 0;
    m_bits.delete();
    m_rr = 0;
    m_gidx = 0;
    m_drop = 0;
    e_valid = 1'b0;
    e_done = 1'b0;
    e_data = '0;
    e_len = '0;
  endfunction

  function automatic int m_pick();
    int c;
    for (int k = 0; k < N; k++) begin
      c = (m_rr + k) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    if (reset && m_phase == 0) begin
      g = m_pick();
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_edge();
    int g;
    int n;
    int l;
    e_valid = 1'b0;
    e_done = 1'b0;
    e_data = '0;
    e_len = '0;
    if (m_phase == 0) begin
      g = m_pick();
      if (g >= 0) begin
        m_gidx = g;
        m_rr = (g + 1) % N;
        l = int'(req_len[g*16 +: 16]);
        if (l == 0 || l > MP) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_len = 16'(l);
          m_addr = req_addr[g*40 +: 40];
          m_bits.delete();
          for (int b = l - 1; b >= 0; b--)
            m_bits.push_back(req_payload[g*MP + b]);
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (int'(tx_budget) >= 56) begin
        e_valid = 1'b1;
        e_len = 6'd56;
        e_data = {m_len, m_addr, 8'h00};
        m_phase = 2;
      end
    end else begin
      n = int'(tx_budget);
      if (m_bits.size() < n) n = m_bits.size();
      if (n > 0) begin
        for (int i = 0; i < n; i++)
          e_data[63-i] = m_bits.pop_front();
        e_len = 6'(n);
        e_valid = 1'b1;
        if (m_bits.size() == 0) begin
          e_done = 1'b1;
          m_phase = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
  endtask

  task automatic fill();
    for (int i = 0; i < N*MP/32; i++)
      req_payload[i*32 +: 32] = $urandom();
  endtask

  task automatic drain();
    int k;
    req_valid = '0;
    tx_budget = 6'd63;
    k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    if (busy) begin
      vecs++;
      errs++;
      $display("FAIL drain_timeout busy=%0b want 0", busy);
    end
    tick();
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    req_len = {16'd8, 16'd8};
    tx_budget = 6'd63;
    repeat (3) @(negedge clk);
    vecs++;
    if (req_ready !== 2'b00) begin
      errs++;
      $display("FAIL rst_ready got %b want 00", req_ready);
    end
    vecs++;
    if (tx_valid !== 1'b0 || tx_len !== 6'd0 ||
        tx_data !== 64'd0) begin
      errs++;
      $display("FAIL rst_tx got v%0b l%0d d%h want 0",
               tx_valid, tx_len, tx_data);
    end
    vecs++;
    if (msg_done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_stat got done%0b busy%0b want 0",
               msg_done, busy);
    end
    vecs++;
    if (grant_idx !== 3'd0 || drop_cnt !== 8'd0) begin
      errs++;
      $display("FAIL rst_cnt got g%0d drop%0d want 0",
               grant_idx, drop_cnt);
    end
    req_valid = '0;
    reset = 1'b1;
    tick();
    vecs++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_idle got busy%0b v%0b want 0",
               busy, tx_valid);
    end
  endtask

  task automatic test_single();
    logic [MP-1:0] pl;
    logic [99:0]   cat;
    fill();
    pl = req_payload[MP-1:0];
    req_len[15:0] = 16'd100;
    req_addr[39:0] = 40'h12_3456_789A;
    tx_budget = 6'd63;
    req_valid = 2'b01;
    #1;
    vecs++;
    if (req_ready !== 2'b01) begin
      errs++;
      $display("FAIL single_ready got %b want 01", req_ready);
    end
    tick();
    req_valid = '0;
    vecs++;
    if (busy !== 1'b1 || tx_valid !== 1'b0 ||
        grant_idx !== 3'd0) begin
      errs++;
      $display("FAIL single_grant got b%0b v%0b g%0d want 1 0 0",
               busy, tx_valid, grant_idx);
    end
    tick();
    vecs++;
    if (tx_valid !== 1'b1 || tx_len !== 6'd56 ||
        tx_data !== {16'h0064, 40'h12_3456_789A, 8'h00}) begin
      errs++;
      $display("FAIL single_hdr got v%0b l%0d d%h want 1 56 %h",
               tx_valid, tx_len, tx_data,
               {16'h0064, 40'h12_3456_789A, 8'h00});
    end
    tick();
    cat[99:37] = tx_data[63:1];
    vecs++;
    if (tx_len !== 6'd63 || tx_data !== {pl[99:37], 1'b0} ||
        msg_done !== 1'b0) begin
      errs++;
      $display("FAIL single_c1 got l%0d d%h done%0b want 63 %h 0",
               tx_len, tx_data, msg_done, {pl[99:37], 1'b0});
    end
    tick();
    cat[36:0] = tx_data[63:27];
    vecs++;
    if (tx_len !== 6'd37 || tx_data !== {pl[36:0], 27'd0} ||
        msg_done !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL single_c2 got l%0d d%h done%0b b%0b want 37 %h 1 0",
               tx_len, tx_data, msg_done, busy, {pl[36:0], 27'd0});
    end
    vecs++;
    if (cat !== pl[99:0]) begin
      errs++;
      $display("FAIL single_cat got %h want %h", cat, pl[99:0]);
    end
  endtask

  task automatic test_hdr_starve();
    logic [MP-1:0] pl;
    fill();
    pl = req_payload[2*MP-1:MP];
    req_len[31:16] = 16'd8;
    req_addr[79:40] = 40'h55_AA55_AA55;
    req_valid = 2'b10;
    tx_budget = 6'd40;
    #1;
    vecs++;
    if (req_ready !== 2'b10) begin
      errs++;
      $display("FAIL starve_ready got %b want 10", req_ready);
    end
    tick();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if (tx_valid !== 1'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL starve_wait%0d got v%0b b%0b want 0 1",
                 i, tx_valid, busy);
      end
    end
    tx_budget = 6'd60;
    tick();
    vecs++;
    if (tx_valid !== 1'b1 || tx_len !== 6'd56 || busy !== 1'b1 ||
        tx_data !== {16'd8, 40'h55_AA55_AA55, 8'h00}) begin
      errs++;
      $display("FAIL starve_hdr got v%0b l%0d b%0b d%h want 1 56 1",
               tx_valid, tx_len, busy, tx_data);
    end
    tick();
    vecs++;
    if (tx_len !== 6'd8 || msg_done !== 1'b1 ||
        tx_data !== {pl[7:0], 56'd0} || grant_idx !== 3'd1) begin
      errs++;
      $display("FAIL starve_pay got l%0d done%0b d%h g%0d want 8 1 %h 1",
               tx_len, msg_done, tx_data, grant_idx, {pl[7:0], 56'd0});
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    int want;
    req_len = {16'd8, 16'd8};
    req_valid = 2'b11;
    tx_budget = 6'd63;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready != '0) begin
        got.push_back(req_ready[1] ? 1 : 0);
        tick();
        vecs++;
        if (grant_idx !== 3'(got[$])) begin
          errs++;
          $display("FAIL rr_gidx got %0d want %0d",
                   grant_idx, got[$]);
        end
      end else begin
        tick();
      end
    end
    req_valid = '0;
    vecs++;
    if (got.size() < 4) begin
      errs++;
      $display("FAIL rr_count got %0d want >=4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      want = i % 2;
      vecs++;
      if (got[i] != want) begin
        errs++;
        $display("FAIL rr_order[%0d] got %0d want %0d",
                 i, got[i], want);
      end
    end
  endtask

  task automatic test_illegal();
    logic [MP-1:0] pl;
    req_len[15:0] = 16'd0;
    req_valid = 2'b01;
    tx_budget = 6'd63;
    #1;
    vecs++;
    if (req_ready !== 2'b01) begin
      errs++;
      $display("FAIL ill_ready0 got %b want 01", req_ready);
    end
    tick();
    vecs++;
    if (drop_cnt !== 8'd1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      errs++;
      $display("FAIL ill_len0 got drop%0d b%0b v%0b want 1 0 0",
               drop_cnt, busy, tx_valid);
    end
    req_len[15:0] = 16'd513;
    #1;
    vecs++;
    if (req_ready !== 2'b01) begin
      errs++;
      $display("FAIL ill_ready513 got %b want 01", req_ready);
    end
    tick();
    req_valid = '0;
    vecs++;
    if (drop_cnt !== 8'd2 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      errs++;
      $display("FAIL ill_len513 got drop%0d b%0b v%0b want 2 0 0",
               drop_cnt, busy, tx_valid);
    end
    tick();
    vecs++;
    if (tx_valid !== 1'b0) begin
      errs++;
      $display("FAIL ill_quiet got v%0b want 0", tx_valid);
    end
    fill();
    pl = req_payload[MP-1:0];
    req_len[15:0] = 16'd20;
    req_addr[39:0] = 40'hAB_CDEF_0123;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    vecs++;
    if (tx_len !== 6'd56 ||
        tx_data !== {16'd20, 40'hAB_CDEF_0123, 8'h00}) begin
      errs++;
      $display("FAIL ill_next_hdr got l%0d d%h want 56", tx_len, tx_data);
    end
    tick();
    vecs++;
    if (tx_len !== 6'd20 || tx_data !== {pl[19:0], 44'd0} ||
        msg_done !== 1'b1 || drop_cnt !== 8'd2) begin
      errs++;
      $display("FAIL ill_next_pay got l%0d d%h done%0b drop%0d want 20 %h 1 2",
               tx_len, tx_data, msg_done, drop_cnt, {pl[19:0], 44'd0});
    end
  endtask

  task automatic test_var_budget();
    logic [MP-1:0] pl;
    int            bl[5];
    int            wl[5];
    logic [63:0]   dat[5];
    logic          dn[5];
    bl = '{63, 0, 5, 63, 63};
    wl = '{56, 0, 5, 63, 2};
    fill();
    pl = req_payload[MP-1:0];
    req_len[15:0] = 16'd70;
    req_addr[39:0] = 40'hFE_DCBA_9876;
    req_valid = 2'b01;
    tx_budget = 6'd0;
    tick();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      tx_budget = 6'(bl[i]);
      tick();
      dat[i] = tx_data;
      dn[i] = msg_done;
      vecs++;
      if (int'(tx_len) != wl[i] || tx_valid !== (wl[i] != 0)) begin
        errs++;
        $display("FAIL vb_len[%0d] got l%0d v%0b want %0d",
                 i, tx_len, tx_valid, wl[i]);
      end
    end
    vecs++;
    if (dat[0] !== {16'd70, 40'hFE_DCBA_9876, 8'h00}) begin
      errs++;
      $display("FAIL vb_hdr got %h", dat[0]);
    end
    vecs++;
    if (dat[2] !== {pl[69:65], 59'd0} ||
        dat[3] !== {pl[64:2], 1'b0} ||
        dat[4] !== {pl[1:0], 62'd0}) begin
      errs++;
      $display("FAIL vb_data got %h %h %h want %h %h %h",
               dat[2], dat[3], dat[4],
               {pl[69:65], 59'd0}, {pl[64:2], 1'b0}, {pl[1:0], 62'd0});
    end
    vecs++;
    if (dn[3] !== 1'b0 || dn[4] !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL vb_done got %0b%0b b%0b want 01 0",
               dn[3], dn[4], busy);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    int k;
    int l;
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 3) == 0)
          req_valid[r] = ~req_valid[r];
        if (!req_valid[r] || $urandom_range(0, 7) == 0) begin
          k = int'($urandom_range(0, 19));
          if (k == 0) l = 0;
          else if (k == 1) l = int'($urandom_range(513, 1000));
          else if (k < 12) l = int'($urandom_range(1, 80));
          else l = int'($urandom_range(81, 512));
          req_len[r*16 +: 16] = 16'(l);
          req_addr[r*40 +: 40] = {8'($urandom()), 32'($urandom())};
          for (int w = 0; w < MP/32; w++)
            req_payload[r*MP + w*32 +: 32] = $urandom();
        end
      end
      k = int'($urandom_range(0, 9));
      if (k == 0) tx_budget = 6'd0;
      else if (k < 4) tx_budget = 6'd63;
      else tx_budget = 6'($urandom_range(1, 62));
      #1;
      er = exp_ready();
      vecs++;
      if (req_ready !== er) begin
        errs++;
        $display("FAIL rnd_ready cyc%0d got %b want %b",
                 c, req_ready, er);
      end
      tick();
      vecs++;
      if ({tx_valid, tx_data, tx_len, msg_done} !==
          {e_valid, e_data, e_len, e_done}) begin
        errs++;
        $display("FAIL rnd_tx cyc%0d got v%0b l%0d d%h done%0b want v%0b l%0d d%h done%0b",
                 c, tx_valid, tx_len, tx_data, msg_done,
                 e_valid, e_len, e_data, e_done);
      end
      vecs++;
      if ({busy, grant_idx, drop_cnt} !==
          {m_phase != 0, 3'(m_gidx), 8'(m_drop)}) begin
        errs++;
        $display("FAIL rnd_stat cyc%0d got b%0b g%0d drop%0d want b%0b g%0d drop%0d",
                 c, busy, grant_idx, drop_cnt,
                 m_phase != 0, m_gidx, m_drop);
      end
    end
  endtask

  task automatic test_reset_mid();
    drain();
    fill();
    req_len[15:0] = 16'd200;
    req_len[31:16] = 16'd8;
    req_valid = 2'b01;
    tx_budget = 6'd63;
    tick();
    req_valid = 2'b11;
    tick();
    vecs++;
    if (tx_len !== 6'd56 || busy !== 1'b1) begin
      errs++;
      $display("FAIL rmid_hdr got l%0d b%0b want 56 1", tx_len, busy);
    end
    tick();
    #2 reset = 1'b0;
    #1;
    vecs++;
    if ({tx_valid, tx_data, tx_len, msg_done, busy,
         grant_idx, drop_cnt} !== '0) begin
      errs++;
      $display("FAIL rmid_clear got v%0b l%0d d%h done%0b b%0b g%0d drop%0d want 0",
               tx_valid, tx_len, tx_data, msg_done, busy,
               grant_idx, drop_cnt);
    end
    vecs++;
    if (req_ready !== 2'b00) begin
      errs++;
      $display("FAIL rmid_ready got %b want 00", req_ready);
    end
    model_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if (msg_done !== 1'b0 || tx_valid !== 1'b0) begin
        errs++;
        $display("FAIL rmid_hold got done%0b v%0b want 0 0",
                 msg_done, tx_valid);
      end
    end
    reset = 1'b1;
    #1;
    vecs++;
    if (req_ready !== 2'b01) begin
      errs++;
      $display("FAIL rmid_rr got %b want 01", req_ready);
    end
    tick();
    req_valid = '0;
    vecs++;
    if (grant_idx !== 3'd0 || busy !== 1'b1 || msg_done !== 1'b0) begin
      errs++;
      $display("FAIL rmid_restart got g%0d b%0b done%0b want 0 1 0",
               grant_idx, busy, msg_done);
    end
    drain();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    req_valid = '0;
    req_len = '0;
    req_addr = '0;
    req_payload = '0;
    tx_budget = '0;
    model_reset();
    test_reset();
    test_single();
    test_hdr_starve();
    test_round_robin();
    drain();
    test_illegal();
    test_var_budget();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ipg_tx_arb.md
# ipg_tx_arb

Round-robin arbiter and serializer for the inter-packet-gap (IPG) transmit slot. Several requesters (write requests, read replies, control) each present a complete IPG message: payload length, address and up to MAX_PAYLOAD payload bits. The block grants one message at a time, then cuts it into header and payload chunks sized to the per-cycle IPG bit budget reported by the PCS. Chunk formatting is exactly what the receive-side write-request processor consumes: MSB-aligned data, with a bit count.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 64, chunk width
- HDR_WIDTH, 16, length field width (payload bits)
- ADR_WIDTH, 40, address field width
- MAX_PAYLOAD, 512, largest legal payload in bits
- HDR_BITS, 56, HDR_WIDTH+ADR_WIDTH, minimum budget to emit a header
---
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  message offered per requester
- req_len  in  NUM_REQ*HDR_WIDTH  payload length in bits, per requester
- req_addr  in  NUM_REQ*ADR_WIDTH  target address, per requester
- req_payload  in  NUM_REQ*MAX_PAYLOAD  payload, bit len-1 transmitted first
- req_ready  out  NUM_REQ  one-hot accept; handshake = valid&ready
- tx_budget  in  6  IPG bits available this cycle (0..63)
- tx_data  out  DATA_WIDTH  chunk, valid bits left-aligned at [63 -: tx_len], rest zero
- tx_len  out  6  valid bits in tx_data
- tx_valid  out  1  chunk present
- busy  out  1  message in flight
- grant_idx  out  3  index of last accepted requester
- msg_done  out  1  one-cycle pulse, last payload chunk emitted
- drop_cnt  out  8  saturating count of dropped illegal messages

## Operation
- States: IDLE, HDR, PAYLOAD.
- **IDLE:** req_ready is combinational. The first requester with req_valid=1 is granted, searching from rr_ptr upward with wrap. Only one ready bit may be high.
- **Handshake capture:** latch len, addr and payload. Pre-shift payload left by MAX_PAYLOAD-len so bit len-1 sits at MAX_PAYLOAD-1. Set rr_ptr = granted+1 mod NUM_REQ and grant_idx = granted.
- **Illegal length:** len==0 or len>MAX_PAYLOAD. The message is accepted and discarded, drop_cnt increments (saturating at 255), state stays IDLE, rr_ptr still advances.
- **Legal length:** go to HDR.
- **HDR:** when tx_budget>=HDR_BITS, emit tx_data = {len, addr, 8'b0} with tx_len=56, then go to PAYLOAD. Otherwise emit nothing and wait; a header is never split.
- **PAYLOAD:** when tx_budget>0:
  - n = min(tx_budget, remain).
  - tx_data = top n bits of the payload register, left-aligned, lower bits zeroed; tx_len = n.
  - Shift the payload register left by n; remain -= n.
  - If remain hits 0, pulse msg_done and go to IDLE.
  - tx_budget=0 means no chunk and no change.
- remain is HDR_WIDTH bits wide and never underflows.
- busy = (state != IDLE).
- req_ready = 0 outside IDLE. Requesters that deassert req_valid before ready are simply not captured.

## Timing
- All outputs except req_ready are registered. At reset: tx_valid=0, tx_data=0, tx_len=0, msg_done=0, busy=0, grant_idx=0, drop_cnt=0, rr_ptr=0, state=IDLE. req_ready is 0 during reset.
- Handshake in cycle T puts state HDR in T+1. If tx_budget>=56 in T+1, the header appears on tx_* in T+2.
- tx_budget sampled in cycle C produces its chunk in C+1. tx_valid=1 only when tx_len>0.
- msg_done is asserted in the same cycle as the final chunk's tx_valid. The next grant may handshake in that same cycle, since state is already IDLE. Back-to-back messages therefore lose no budget cycle beyond the header wait.
- Simultaneous valid from all requesters: each is served once in rotation before any is served twice.
- Reset mid-message: immediate asynchronous clear. The partial message is lost, and no msg_done is emitted.
- Worst case, MAX_PAYLOAD=512 at budget 63: 1 header + 9 payload chunks (8×63 + 8).

## Test plan
- **Single legal message.** Req0 with len=100, addr=0x12_3456_789A, budget fixed at 63. Expected:
  - header chunk {16'h0064, 40'h123456789A, 8'h00}, tx_len=56;
  - then a 63-bit chunk and a 37-bit chunk, MSB-aligned;
  - msg_done with the 37-bit chunk; concatenated payload matches.
- **Header starvation.** Budget 40 for 5 cycles, then 60. Expected: no tx_valid during the 40-budget cycles, header on the cycle after 60 is sampled, busy held high throughout.
- **Round-robin.** Req0 and req1 both valid continuously with len=8. Expected: grants alternate 0,1,0,1 and grant_idx follows.
- **Illegal length.** len=0, then len=513. Expected: both accepted, no tx_valid, drop_cnt=2, next legal message transmitted normally.
- **Variable budget.** Budget sequence 63,0,5,63,63 with len=70. Expected payload chunk lengths 0(none),5,63,2, with remain ending at 0.
- **Reset mid-message.** Assert reset after the header. Expected: all outputs return to reset values asynchronously, and after release the next request starts from IDLE with rr_ptr=0.
